// File: rtl/sin_phase_gen.sv
// ---------------------------------------------------------------------------
// sin_phase_gen
//   Phase-accumulator (NCO) front end for the quadratic sine evaluator.
//   Emits one phase word per cycle while running a burst (finite or
//   continuous), then waits for the evaluator pipeline to drain and pulses
//   done_o so it lines up with the last sine sample leaving the evaluator.
//
//   Optional feature macro: SIN_PHASE_SWEEP_EN
//     defined   -> cfg_dfcw_i port present; FCW ramps linearly per sample
//     undefined -> constant FCW, no sweep logic
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   cfg_valid_i/ready_o    config handshake (ready only in IDLE)
//   cfg_fcw_i              frequency control word
//   cfg_off_i              starting phase
//   cfg_count_i            samples per burst, 0 = continuous
//   cfg_dfcw_i             signed FCW increment per sample (sweep only)
//   start_i, stop_i        start / abort burst
//   phase_o, valid_o       phase word to evaluator and its strobe
//   busy_o                 not idle
//   done_o                 one-cycle completion pulse
// ---------------------------------------------------------------------------
module sin_phase_gen #(
  parameter int PHASE_BITS = 47,
  parameter int COUNT_BITS = 16,
  parameter int PIPE_LAT   = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  input  logic [PHASE_BITS-1:0] cfg_fcw_i,
  input  logic [PHASE_BITS-1:0] cfg_off_i,
  input  logic [COUNT_BITS-1:0] cfg_count_i,
`ifdef SIN_PHASE_SWEEP_EN
  input  logic [PHASE_BITS-1:0] cfg_dfcw_i,
`endif
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic [PHASE_BITS-1:0] phase_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DW = $clog2(PIPE_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;

  logic [PHASE_BITS-1:0] r_fcw;
  logic [PHASE_BITS-1:0] r_off;
  logic [COUNT_BITS-1:0] r_count;
`ifdef SIN_PHASE_SWEEP_EN
  logic [PHASE_BITS-1:0] r_dfcw;
`endif

  logic [PHASE_BITS-1:0] r_acc;    // phase of the next sample to issue
  logic [PHASE_BITS-1:0] r_step;   // FCW applied after the next sample
  logic [COUNT_BITS-1:0] r_cnt;    // samples issued so far in this burst
  logic [DW-1:0]         r_drain;
  logic [PHASE_BITS-1:0] r_phase;
  logic                  r_valid;

  logic                  w_start;
  logic                  w_last;

  assign w_start = start_i && !stop_i;
  assign w_last  = (r_count != '0) && (r_cnt == r_count - COUNT_BITS'(1));

  assign cfg_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = (r_state == S_DONE);
  assign phase_o     = r_phase;
  assign valid_o     = r_valid;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Outputs are registered one cycle behind the state, so the first DRAIN
  // cycle still carries the final sample on valid_o. DRAIN therefore lasts
  // PIPE_LAT+1 state cycles: one overlap plus PIPE_LAT empty cycles.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (stop_i || w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_drain == DW'(PIPE_LAT)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Config registers: only writable while idle
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fcw   <= '0;
      r_off   <= '0;
      r_count <= '0;
`ifdef SIN_PHASE_SWEEP_EN
      r_dfcw  <= '0;
`endif
    end else if (cfg_valid_i && cfg_ready_o) begin
      r_fcw   <= cfg_fcw_i;
      r_off   <= cfg_off_i;
      r_count <= cfg_count_i;
`ifdef SIN_PHASE_SWEEP_EN
      r_dfcw  <= cfg_dfcw_i;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Accumulator / sample counter / drain counter / output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc   <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      r_phase <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_acc  <= r_off;
            r_step <= r_fcw;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_phase <= r_acc;
          r_valid <= 1'b1;
          r_acc   <= r_acc + r_step;   // wraps mod 2^PHASE_BITS
`ifdef SIN_PHASE_SWEEP_EN
          r_step  <= r_step + r_dfcw;  // two's complement chirp, wraps
`endif
          r_cnt   <= r_cnt + COUNT_BITS'(1);
          r_drain <= '0;
        end
        S_DRAIN: r_drain <= r_drain + DW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sin_phase_gen.sv
module tb_sin_phase_gen;
  localparam int PB = 47;
  localparam int CB = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [PB-1:0] cfg_fcw_i = '0;
  logic [PB-1:0] cfg_off_i = '0;
  logic [CB-1:0] cfg_count_i = '0;
`ifdef SIN_PHASE_SWEEP_EN
  logic [PB-1:0] cfg_dfcw_i = '0;
`endif
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic [PB-1:0] phase_o;
  logic          valid_o;
  logic          busy_o;
  logic          done_o;

  sin_phase_gen #(.PHASE_BITS(PB), .COUNT_BITS(CB), .PIPE_LAT(5)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_fcw_i(cfg_fcw_i), .cfg_off_i(cfg_off_i), .cfg_count_i(cfg_count_i),
`ifdef SIN_PHASE_SWEEP_EN
    .cfg_dfcw_i(cfg_dfcw_i),
`endif
    .start_i(start_i), .stop_i(stop_i),
    .phase_o(phase_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;
  int             last_v = -100;
  int             done_seen = 0;
  int             exp_done = 0;
  logic [PB-1:0]  exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pops an expected phase for every valid_o cycle and
  // checks done_o lands PIPE_LAT+1 = 6 cycles after the last valid sample.
  always @(negedge clk) begin
    if (resetn) begin
      if (valid_o) begin
        if (exp_q.size() == 0) chk("unexpected_valid", 64'(phase_o), 64'hdead);
        else chk("phase", 64'(phase_o), 64'(exp_q.pop_front()));
        last_v = cyc;
      end
      if (done_o) begin
        chk("done_latency", 64'(cyc - last_v), 64'd6);
        done_seen++;
      end
    end
  end

  task automatic cfg(input logic [PB-1:0] fcw, input logic [PB-1:0] off,
                     input logic [CB-1:0] cnt, input logic [PB-1:0] dfcw);
    @(negedge clk);
    cfg_fcw_i = fcw; cfg_off_i = off; cfg_count_i = cnt;
`ifdef SIN_PHASE_SWEEP_EN
    cfg_dfcw_i = dfcw;
`else
    if (dfcw != '0) $display("note: dfcw ignored without sweep");
`endif
    cfg_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_valid_i = 1'b0;
  endtask

  task automatic start_burst();
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done_o) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("busy_after_done", 64'(busy_o), 64'd0);
    chk("ready_after_done", 64'(cfg_ready_o), 64'd1);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_phase", 64'(phase_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(cfg_ready_o), 64'd1);
    @(negedge clk);
    resetn = 1'b1;

    // 1: basic 4-sample burst
    cfg(47'h0100_0000_0000, 47'd0, 16'd4, 47'd0);
    exp_q.push_back(47'h0);
    exp_q.push_back(47'h0100_0000_0000);
    exp_q.push_back(47'h0200_0000_0000);
    exp_q.push_back(47'h0300_0000_0000);
    exp_done++;
    start_burst();
    chk("busy_run", 64'(busy_o), 64'd1);
    wait_done();

    // 2: wraparound
    cfg(47'h4000_0000_0000, 47'h2000_0000_0000, 16'd3, 47'd0);
    exp_q.push_back(47'h2000_0000_0000);
    exp_q.push_back(47'h6000_0000_0000);
    exp_q.push_back(47'h2000_0000_0000);
    exp_done++;
    start_burst();
    wait_done();

    // 3: continuous, stopped on the 10th sample
    cfg(47'd1, 47'd0, 16'd0, 47'd0);
    for (int k = 0; k < 10; k++) exp_q.push_back(PB'(k));
    exp_done++;
    start_burst();
    repeat (9) @(posedge clk);
    @(negedge clk);
    stop_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stop_i = 1'b0;
    wait_done();

    // 4: config and start during RUN are ignored
    cfg(47'd3, 47'd100, 16'd4, 47'd0);
    exp_q.push_back(47'd100); exp_q.push_back(47'd103);
    exp_q.push_back(47'd106); exp_q.push_back(47'd109);
    exp_done++;
    start_burst();
    cfg_fcw_i = 47'd7; cfg_valid_i = 1'b1; start_i = 1'b1;
    #1;
    chk("ready_in_run", 64'(cfg_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    cfg_valid_i = 1'b0; start_i = 1'b0;
    wait_done();
    exp_q.push_back(47'd100); exp_q.push_back(47'd103);
    exp_q.push_back(47'd106); exp_q.push_back(47'd109);
    exp_done++;
    start_burst();
    wait_done();

    // 5: reset mid-burst, then start+stop together in IDLE
    cfg(47'd1, 47'd0, 16'd8, 47'd0);
    exp_q.push_back(47'd0); exp_q.push_back(47'd1); exp_q.push_back(47'd2);
    start_burst();
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("mid_rst_phase", 64'(phase_o), 64'd0);
    chk("mid_rst_valid", 64'(valid_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_done", 64'(done_o), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'(cfg_ready_o), 64'd1);
    start_i = 1'b1; stop_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0;
    chk("start_stop_idle", 64'(busy_o), 64'd0);
    repeat (10) @(negedge clk);

`ifdef SIN_PHASE_SWEEP_EN
    // 6: linear chirp
    cfg(47'd4, 47'd0, 16'd5, {PB{1'b1}});
    exp_q.push_back(47'd0); exp_q.push_back(47'd4); exp_q.push_back(47'd7);
    exp_q.push_back(47'd9); exp_q.push_back(47'd10);
    exp_done++;
    start_burst();
    wait_done();
`endif

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_seen), 64'(exp_done));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
